// File: rtl/button_event_conditioner.sv
// Purpose: synchronise, debounce and edge-detect push-buttons; queue press events on a one-hot valid/ready channel.
// Latency: clean raw edge -> btn_level/pulse after 2 + DB_CYCLES + 1 clk; press pulse -> event_valid 1 clk later.
// Backpressure: 1-deep event register; while valid & !ready it holds, and new presses are dropped with event_drop.
module button_event_conditioner #(
  parameter int NBTN      = 3,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic            event_valid,
  output logic [NBTN-1:0] event_code,
  input  logic            event_ready,
  output logic            event_drop
);

  // Counter only has to reach DB_CYCLES-1, so $clog2(DB_CYCLES) bits suffice.
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  // Debounce states. LOW/RISE report level 0, HIGH/FALL report level 1.
  localparam logic [1:0] ST_LOW  = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_FALL = 2'd3;

  logic [NBTN-1:0] sync_meta;
  logic [NBTN-1:0] sync_q;

  logic [1:0]      st_q    [NBTN];
  logic [1:0]      st_nxt  [NBTN];
  logic [CW-1:0]   cnt_q   [NBTN];
  logic [CW-1:0]   cnt_nxt [NBTN];
  logic [NBTN-1:0] level_nxt;
  logic [NBTN-1:0] press_nxt;
  logic [NBTN-1:0] release_nxt;

  logic [NBTN-1:0] sel_onehot;
  logic [NBTN-1:0] others;
  logic            any_press;
  logic            can_load;

  // Two-flop synchroniser on every raw button bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
    end
  end

  // Per-button debounce next-state: a level is accepted only after a full stable run.
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      st_nxt[i]      = st_q[i];
      cnt_nxt[i]     = cnt_q[i];
      press_nxt[i]   = 1'b0;
      release_nxt[i] = 1'b0;
      case (st_q[i])
        ST_LOW: begin
          if (sync_q[i]) begin
            st_nxt[i]  = ST_RISE;
            cnt_nxt[i] = '0;
          end
        end
        ST_RISE: begin
          if (!sync_q[i]) begin
            st_nxt[i] = ST_LOW;
          end else if (cnt_q[i] == CNT_MAX) begin
            st_nxt[i]    = ST_HIGH;
            press_nxt[i] = 1'b1;
          end else begin
            cnt_nxt[i] = cnt_q[i] + CW'(1);
          end
        end
        ST_HIGH: begin
          if (!sync_q[i]) begin
            st_nxt[i]  = ST_FALL;
            cnt_nxt[i] = '0;
          end
        end
        ST_FALL: begin
          if (sync_q[i]) begin
            st_nxt[i] = ST_HIGH;
          end else if (cnt_q[i] == CNT_MAX) begin
            st_nxt[i]      = ST_LOW;
            release_nxt[i] = 1'b1;
          end else begin
            cnt_nxt[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          st_nxt[i]  = ST_LOW;
          cnt_nxt[i] = '0;
        end
      endcase
      level_nxt[i] = (st_nxt[i] == ST_HIGH) || (st_nxt[i] == ST_FALL);
    end
  end

  // Debounce state, counters and the registered level/pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NBTN; i++) begin
        st_q[i]  <= ST_LOW;
        cnt_q[i] <= '0;
      end
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        st_q[i]  <= st_nxt[i];
        cnt_q[i] <= cnt_nxt[i];
      end
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
    end
  end

  // Lowest-index press wins; any further simultaneous presses are lost.
  assign sel_onehot = btn_press & (~btn_press + NBTN'(1));
  assign others     = btn_press & ~sel_onehot;
  assign any_press  = |btn_press;
  // The register may load when empty or when its current event is being taken this edge.
  assign can_load   = !event_valid || event_ready;

  // One-deep event register; contents are frozen while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      event_valid <= 1'b0;
      event_code  <= '0;
      event_drop  <= 1'b0;
    end else begin
      event_drop <= any_press && (!can_load || (|others));
      if (can_load) begin
        event_valid <= any_press;
        event_code  <= sel_onehot;
      end
    end
  end

endmodule

// File: tb/tb_button_event_conditioner.sv
// Bench for button_event_conditioner: directed scenarios plus randomized bouncing/backpressure,
// every cycle compared against a run-length / queue reference model.
module tb_button_event_conditioner;
  localparam int NBTN = 3;
  localparam int DB   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_press;
  logic [2:0] btn_release;
  logic       event_valid;
  logic [2:0] event_code;
  logic       event_ready;
  logic       event_drop;

  always #5 clk = ~clk;

  button_event_conditioner #(.NBTN(NBTN), .DB_CYCLES(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .event_valid (event_valid),
    .event_code  (event_code),
    .event_ready (event_ready),
    .event_drop  (event_drop)
  );

  int    vec_cnt = 0;
  int    err_cnt = 0;
  string phase   = "init";

  // Reference model state: raw history (two-cycle sync delay), run lengths, event queue.
  logic [2:0] m_h1, m_h2, m_level, m_press, m_rel;
  logic       m_drop;
  int         m_run [NBTN];
  logic [2:0] m_q [$];

  // Directed bookkeeping from DUT outputs.
  int press_cnt [NBTN];
  int rel_cnt   [NBTN];
  int drop_cnt;
  int valid_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h1 = '0; m_h2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_drop = 1'b0;
    m_q.delete();
    for (int i = 0; i < NBTN; i++) m_run[i] = 0;
  endtask

  // A level flips once the synchronised input has disagreed with it for DB+1 consecutive samples.
  task automatic model_step(input logic [2:0] raw, input logic rdy);
    logic [2:0] old_press, samp, pick;
    old_press = m_press;
    samp = m_h2; m_h2 = m_h1; m_h1 = raw;
    m_press = '0; m_rel = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (samp[i] != m_level[i]) m_run[i]++; else m_run[i] = 0;
      if (m_run[i] == DB + 1) begin
        m_run[i] = 0;
        m_level[i] = !m_level[i];
        if (m_level[i]) m_press[i] = 1'b1; else m_rel[i] = 1'b1;
      end
    end
    if (m_q.size() > 0 && rdy) m_q.delete(0);
    m_drop = 1'b0;
    if (old_press != 3'b000) begin
      pick = '0;
      for (int i = NBTN - 1; i >= 0; i--) if (old_press[i]) pick = 3'b001 << i;
      if (m_q.size() == 0) begin
        m_q.push_back(pick);
        if (old_press != pick) m_drop = 1'b1;
      end else begin
        m_drop = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input string ph);
    logic [2:0] ec;
    ec = (m_q.size() > 0) ? m_q[0] : 3'b000;
    check({ph, ".level"},   btn_level,   m_level);
    check({ph, ".press"},   btn_press,   m_press);
    check({ph, ".release"}, btn_release, m_rel);
    check({ph, ".valid"},   event_valid, m_q.size() > 0);
    check({ph, ".code"},    event_code,  ec);
    check({ph, ".drop"},    event_drop,  m_drop);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NBTN; i++) begin press_cnt[i] = 0; rel_cnt[i] = 0; end
    drop_cnt = 0; valid_cnt = 0;
  endtask

  // One clock: drive at negedge, model the posedge, compare 1 time unit later.
  task automatic cyc(input logic [2:0] raw, input logic rdy, input logic r);
    @(negedge clk);
    btn_raw = raw;
    event_ready = rdy;
    if (!r && rst) begin
      rst = 1'b0;
      #1;
      model_reset();
      compare_all({phase, ".async"});
    end
    rst = r;
    @(posedge clk);
    if (!rst) model_reset(); else model_step(raw, rdy);
    #1;
    compare_all(phase);
    for (int i = 0; i < NBTN; i++) begin
      press_cnt[i] += int'(btn_press[i]);
      rel_cnt[i]   += int'(btn_release[i]);
    end
    drop_cnt  += int'(event_drop);
    valid_cnt += int'(event_valid);
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) cyc(3'b000, 1'b1, 1'b1);
  endtask

  initial begin
    int         hold [NBTN];
    logic [2:0] rv;
    logic       rdy;
    int         press_at;

    rst = 1'b0; btn_raw = '0; event_ready = 1'b0;
    model_reset();
    clear_counts();

    // Reset with all buttons held, then release and hold.
    phase = "t1_reset";
    for (int k = 0; k < 3; k++) cyc(3'b111, 1'b0, 1'b0);
    clear_counts();
    for (int k = 0; k < 12; k++) begin
      cyc(3'b111, 1'b0, 1'b1);
      if (k == 5) check("t1.level_before", btn_level, 3'b000);
      if (k == 6) check("t1.level_at7",    btn_level, 3'b111);
    end
    check("t1.drop_cnt", drop_cnt, 1);
    check("t1.code_held", event_code, 3'b001);
    settle(14);

    // Bounce on button 1, final rise at k=18.
    phase = "t2_bounce";
    clear_counts();
    press_at = -1;
    for (int k = 0; k < 40; k++) begin
      if (k < 20) cyc((((k / 2) % 2) != 0) ? 3'b010 : 3'b000, 1'b1, 1'b1);
      else        cyc(3'b010, 1'b1, 1'b1);
      if (btn_press[1] && press_at < 0) press_at = k;
    end
    check("t2.press_cnt", press_cnt[1], 1);
    check("t2.press_at", press_at, 24);
    settle(14);

    // Short glitch on button 0.
    phase = "t3_glitch";
    clear_counts();
    for (int k = 0; k < 3; k++) cyc(3'b001, 1'b1, 1'b1);
    settle(12);
    check("t3.press_cnt", press_cnt[0], 0);
    check("t3.valid_cnt", valid_cnt, 0);

    // Backpressure: btn0 then btn2 with ready low.
    phase = "t4_backpressure";
    clear_counts();
    for (int k = 0; k < 10; k++) cyc(3'b001, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) cyc(3'b101, 1'b0, 1'b1);
    check("t4.drop_cnt", drop_cnt, 1);
    check("t4.code_held", event_code, 3'b001);
    cyc(3'b101, 1'b1, 1'b1);
    check("t4.valid_after_accept", event_valid, 1'b0);
    settle(14);

    // Back-to-back presses one cycle apart with ready high.
    phase = "t5_b2b";
    clear_counts();
    cyc(3'b001, 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) cyc(3'b011, 1'b1, 1'b1);
    check("t5.valid_cnt", valid_cnt, 2);
    check("t5.drop_cnt", drop_cnt, 0);
    settle(14);

    // Clean release of button 2.
    phase = "t6_release";
    for (int k = 0; k < 10; k++) cyc(3'b100, 1'b1, 1'b1);
    clear_counts();
    press_at = -1;
    for (int k = 0; k < 12; k++) begin
      cyc(3'b000, 1'b1, 1'b1);
      if (btn_release[2] && press_at < 0) press_at = k;
    end
    check("t6.rel_cnt", rel_cnt[2], 1);
    check("t6.rel_at", press_at, 6);
    check("t6.valid_cnt", valid_cnt, 0);

    // Reset in the middle of debouncing, then re-press with buttons already high.
    phase = "t7_mid_reset";
    for (int k = 0; k < 4; k++) cyc(3'b111, 1'b1, 1'b1);
    cyc(3'b111, 1'b1, 1'b0);
    cyc(3'b111, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) cyc(3'b111, 1'b1, 1'b1);
    settle(14);

    // Randomized bouncing, backpressure and occasional resets.
    phase = "rand";
    for (int i = 0; i < NBTN; i++) hold[i] = 0;
    rv = '0;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NBTN; i++) begin
        if (hold[i] == 0) begin
          rv[i] = 1'($urandom_range(0, 1));
          hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 14));
        end
        hold[i]--;
      end
      rdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 599) == 0) begin
        cyc(rv, rdy, 1'b0);
        cyc(rv, rdy, 1'b0);
      end else begin
        cyc(rv, rdy, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
